// File: rtl/io_pkg.sv
// Shared constants for the memory-mapped display/switch peripheral: segment
// table, anode idle pattern, digit count and the I/O address it decodes at.
package io_pkg;

    localparam logic [31:0] IO_ADDR = 32'd4096;
    localparam logic [3:0]  AN_OFF  = 4'hF;
    localparam int          NUM_DIG = 3;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        return SEG_HEX[value];
    endfunction

endpackage

// File: rtl/io_display_switch_ctrl_if.sv
// Memory-stage side of the I/O peripheral: display word in, switch word and
// change strobe out.
interface io_display_switch_ctrl_if;
    import io_pkg::*;

    logic [11:0] iomem;
    logic [15:0] ioin;
    logic        sw_change;

    modport master (output iomem, input ioin, input sw_change);
    modport slave  (input iomem, output ioin, output sw_change);

endinterface

// File: rtl/io_sync_debounce.sv
// Two-flop synchroniser plus whole-vector debounce for the board switches.
// The shared debounce counter exists only when IO_DEBOUNCE_EN is defined.
module io_sync_debounce
    import io_pkg::*;
#(
    parameter int DEB_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] sw,
    output logic [15:0] ioin,
    output logic        sw_change
);

    logic [15:0] s1;
    logic [15:0] s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int             CNT_W   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [15:0]      cand;
    logic [CNT_W-1:0] cnt;

    // Any difference from the candidate restarts the count; once saturated the
    // candidate is committed every cycle, but only a real change strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand      <= '0;
            cnt       <= '0;
            ioin      <= '0;
            sw_change <= 1'b0;
        end else begin
            sw_change <= 1'b0;
            if (s2 != cand) begin
                cand <= s2;
                cnt  <= '0;
            end else if (cnt == CNT_MAX) begin
                ioin      <= cand;
                sw_change <= (cand != ioin);
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ioin      <= '0;
            sw_change <= 1'b0;
        end else begin
            ioin      <= s2;
            sw_change <= (s2 != ioin);
        end
    end
`endif

endmodule

// File: rtl/io_display_switch_ctrl.sv
// Display/switch I/O peripheral: scans iomem as 3 hex digits on a 4-digit
// 7-seg display and returns debounced switches (optional IO_DEBOUNCE_EN).
module io_display_switch_ctrl
    import io_pkg::*;
#(
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 16,
    parameter int DEB_CYCLES = 500000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    io_display_switch_ctrl_if.slave  bus,
    input  logic [15:0]              sw,
    output logic [6:0]               seg,
    output logic                     dp,
    output logic [3:0]               an
);

    localparam int              SC_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SC_W-1:0] SCAN_MAX = SC_W'(SCAN_DIV - 1);
    localparam logic [SC_W-1:0] BLANK    = SC_W'(BLANK_CYC);
    localparam logic [1:0]      LAST_DIG = 2'(NUM_DIG - 1);

    logic [SC_W-1:0] scan_cnt;
    logic [1:0]      dig;
    logic [11:0]     disp_q;
    logic            loaded;
    logic [3:0]      nibble;

    // disp_q only reloads at a frame boundary so a mid-frame iomem write
    // cannot show half-old, half-new digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            dig      <= '0;
            disp_q   <= '0;
            loaded   <= 1'b0;
        end else begin
            loaded <= 1'b1;
            if (scan_cnt == SCAN_MAX) begin
                scan_cnt <= '0;
                dig      <= (dig == LAST_DIG) ? 2'd0 : dig + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            if (!loaded || (scan_cnt == SCAN_MAX && dig == LAST_DIG)) begin
                disp_q <= bus.iomem;
            end
        end
    end

    always_comb begin
        nibble = 4'h0;
        case (dig)
            2'd0:    nibble = disp_q[3:0];
            2'd1:    nibble = disp_q[7:4];
            2'd2:    nibble = disp_q[11:8];
            default: nibble = 4'h0;
        endcase
    end

    assign seg = hex_to_seg(nibble);
    assign an  = (scan_cnt < BLANK) ? AN_OFF : ~(4'b0001 << dig);
    assign dp  = 1'b1;

    io_sync_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_sync_debounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw        (sw),
        .ioin      (bus.ioin),
        .sw_change (bus.sw_change)
    );

endmodule

// File: tb/tb_io_display_switch_ctrl.sv
// Directed bench for io_display_switch_ctrl (SCAN_DIV=8, BLANK_CYC=2, DEB_CYCLES=4);
// switch latency expectations follow IO_DEBOUNCE_EN.
module tb_io_display_switch_ctrl;

    localparam int SCAN_DIV   = 8;
    localparam int BLANK_CYC  = 2;
    localparam int DEB_CYCLES = 4;
`ifdef IO_DEBOUNCE_EN
    localparam int SW_LAT       = DEB_CYCLES + 3;
    localparam int BOUNCE_PULSE = 1;
`else
    localparam int SW_LAT       = 3;
    localparam int BOUNCE_PULSE = 11;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] sw;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    io_display_switch_ctrl_if bus_if ();

    io_display_switch_ctrl #(
        .SCAN_DIV   (SCAN_DIV),
        .BLANK_CYC  (BLANK_CYC),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if),
        .sw    (sw),
        .seg   (seg),
        .dp    (dp),
        .an    (an)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic        set_io;
        logic [11:0] io;
        logic [3:0]  an;
        logic [6:0]  seg;
    } scan_vec_t;

    scan_vec_t   vecs [20];
    int          total = 0;
    int          bad   = 0;
    int          n     = 0;
    int          pulses;
    logic [15:0] hist [$];
    logic [15:0] exp_in;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h (n=%0d)", name, act, exp, n);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // n = edges since reset release; expected an/seg hand-derived per slot
        vecs[0]  = '{0,  1'b0, 12'h000, 4'hF, 7'h40};
        vecs[1]  = '{1,  1'b0, 12'h000, 4'hF, 7'h46};
        vecs[2]  = '{2,  1'b0, 12'h000, 4'hE, 7'h46};
        vecs[3]  = '{7,  1'b0, 12'h000, 4'hE, 7'h46};
        vecs[4]  = '{8,  1'b0, 12'h000, 4'hF, 7'h12};
        vecs[5]  = '{10, 1'b0, 12'h000, 4'hD, 7'h12};
        vecs[6]  = '{15, 1'b0, 12'h000, 4'hD, 7'h12};
        vecs[7]  = '{16, 1'b0, 12'h000, 4'hF, 7'h08};
        vecs[8]  = '{18, 1'b0, 12'h000, 4'hB, 7'h08};
        vecs[9]  = '{23, 1'b0, 12'h000, 4'hB, 7'h08};
        vecs[10] = '{24, 1'b0, 12'h000, 4'hF, 7'h46};
        vecs[11] = '{26, 1'b0, 12'h000, 4'hE, 7'h46};
        vecs[12] = '{34, 1'b1, 12'h123, 4'hD, 7'h12};
        vecs[13] = '{35, 1'b0, 12'h000, 4'hD, 7'h12};
        vecs[14] = '{42, 1'b0, 12'h000, 4'hB, 7'h08};
        vecs[15] = '{48, 1'b0, 12'h000, 4'hF, 7'h30};
        vecs[16] = '{50, 1'b0, 12'h000, 4'hE, 7'h30};
        vecs[17] = '{58, 1'b0, 12'h000, 4'hD, 7'h24};
        vecs[18] = '{66, 1'b0, 12'h000, 4'hB, 7'h79};
        vecs[19] = '{74, 1'b0, 12'h000, 4'hE, 7'h30};

        rst_n        = 1'b0;
        sw           = 16'h0000;
        bus_if.iomem = 12'hA5C;
        repeat (3) @(negedge clk);
        check("reset_an",        32'(an),               32'hF);
        check("reset_seg",       32'(seg),              32'h40);
        check("reset_dp",        32'(dp),               32'h1);
        check("reset_ioin",      32'(bus_if.ioin),      32'h0);
        check("reset_sw_change", 32'(bus_if.sw_change), 32'h0);

        rst_n = 1'b1;
        n     = 0;
        for (int i = 0; i < 20; i++) begin
            while (n < vecs[i].n) step();
            check("scan_an",  32'(an),  32'(vecs[i].an));
            check("scan_seg", 32'(seg), 32'(vecs[i].seg));
            check("scan_dp",  32'(dp),  32'h1);
            if (vecs[i].set_io) bus_if.iomem = vecs[i].io;
        end

        // Clean switch change: ioin and one-cycle strobe land on edge SW_LAT
        sw = 16'h8001;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("deb_ioin",      32'(bus_if.ioin),      (k >= SW_LAT) ? 32'h8001 : 32'h0);
            check("deb_sw_change", 32'(bus_if.sw_change), (k == SW_LAT) ? 32'h1 : 32'h0);
        end

        sw = 16'h0000;
        repeat (12) step();
        check("pre_bounce_ioin", 32'(bus_if.ioin), 32'h0);

        pulses = 0;
        for (int t = 0; t < 50; t++) begin
            if (t < 30) sw = (((t / 3) % 2) == 0) ? 16'h0010 : 16'h0000;
            else        sw = 16'h0010;
            hist.push_back(sw);
            step();
            if (bus_if.sw_change === 1'b1) pulses++;
`ifdef IO_DEBOUNCE_EN
            if (t < 30) check("bounce_ioin", 32'(bus_if.ioin), 32'h0);
`else
            exp_in = (t >= 2) ? hist[t-2] : 16'h0000;
            check("follow_ioin", 32'(bus_if.ioin), 32'(exp_in));
`endif
        end
        check("bounce_final_ioin", 32'(bus_if.ioin), 32'h0010);
        check("bounce_pulses",     32'(pulses),      32'(BOUNCE_PULSE));

        // Async reset with a switch value still in the synchroniser
        sw = 16'h0F0F;
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("async_an",        32'(an),               32'hF);
        check("async_seg",       32'(seg),              32'h40);
        check("async_ioin",      32'(bus_if.ioin),      32'h0);
        check("async_sw_change", 32'(bus_if.sw_change), 32'h0);
        check("async_dp",        32'(dp),               32'h1);
        bus_if.iomem = 12'h7E4;
        sw           = 16'h0000;
        repeat (3) @(negedge clk);
        check("held_reset_an", 32'(an), 32'hF);

        rst_n  = 1'b1;
        n      = 0;
        pulses = 0;
        step();
        check("relatch_an",  32'(an),  32'hF);
        check("relatch_seg", 32'(seg), 32'h19);
        step();
        check("relatch_an2", 32'(an),  32'hE);
        while (n < 10) begin
            step();
            if (bus_if.sw_change === 1'b1) pulses++;
        end
        check("relatch_dig1_an",  32'(an),          32'hD);
        check("relatch_dig1_seg", 32'(seg),         32'h06);
        check("discard_ioin",     32'(bus_if.ioin), 32'h0);
        check("discard_pulses",   32'(pulses),      32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
